// File: rtl/spi_motor_cmd_ctrl.sv
// SPI command decoder and motor register file: tracks chip select and byte count,
// builds response bytes, and commits duty / enable writes on exact-length transfers.
module spi_motor_cmd_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int DUTY_WIDTH   = 10,
  parameter int ENC_WIDTH    = 16,
  parameter int WDT_WIDTH    = 24,
  parameter int WDT_TIMEOUT  = 1000000
) (
  input  logic                               sysclk,
  input  logic                               rst,
  input  logic                               ncs_s,
  input  logic                               byte_done,
  input  logic [7:0]                         rx_byte,
  input  logic [NUM_CHANNELS*ENC_WIDTH-1:0]  enc_count,
  output logic [7:0]                         tx_byte,
  output logic [NUM_CHANNELS*DUTY_WIDTH-1:0] duty,
  output logic                               motors_en,
  output logic                               wdt_expired,
  output logic                               commit,
  output logic                               xfer_err
);

  localparam int BUF_LEN = 1 + 2 * NUM_CHANNELS;
  localparam int IDX_W   = $clog2(BUF_LEN + 1);
  localparam logic [IDX_W-1:0]     IDX_MAX  = '1;
  localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_WIDTH'(WDT_TIMEOUT - 1);

  localparam logic [1:0] K_UPD = 2'd0;
  localparam logic [1:0] K_RDD = 2'd1;
  localparam logic [1:0] K_SEN = 2'd2;
  localparam logic [1:0] K_BAD = 2'd3;

  function automatic logic [1:0] decode_cmd(input logic [7:0] b);
    if (b[6:0] == 7'd0)  return K_UPD;
    if (b == 8'h81)      return K_RDD;
    if (b == 8'h02)      return K_SEN;
    return K_BAD;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  logic                              ncs_d;
  logic                              active;
  logic [IDX_W-1:0]                  byte_idx;
  logic                              overflow;
  logic [1:0]                        kind_q;
  logic                              last_err;
  logic [WDT_WIDTH-1:0]              wdt_cnt;
  logic [NUM_CHANNELS*DUTY_WIDTH-1:0] duty_q;
  logic [NUM_CHANNELS*ENC_WIDTH-1:0] snap_q;
  logic [7:0]                        req_buf [BUF_LEN];

  logic                              start, stop_evt, take, ovf_n, len_ok, accept, upd_acc;
  logic [1:0]                        kind_n;
  logic [IDX_W:0]                    cnt_n;
  logic [7:0]                        buf_n [BUF_LEN];
  logic [NUM_CHANNELS*DUTY_WIDTH-1:0] duty_new;
  logic [NUM_CHANNELS*ENC_WIDTH-1:0] snap_src;
  logic [ENC_WIDTH-1:0]              enc_sel;
  logic [DUTY_WIDTH-1:0]             duty_sel;
  logic [7:0]                        tx_next;
  logic [7:0]                        status;

  assign start    = ncs_d & ~ncs_s;
  assign stop_evt = active & ~ncs_d & ncs_s;
  // A byte coinciding with a start strobe is dropped; one coinciding with the end still counts.
  assign take     = byte_done & active & ~start;
  assign kind_n   = (take && byte_idx == '0) ? decode_cmd(rx_byte) : kind_q;
  assign ovf_n    = overflow | (take && byte_idx >= IDX_W'(BUF_LEN));
  assign cnt_n    = {1'b0, byte_idx} + {{IDX_W{1'b0}}, take};
  assign status   = {2'b10, motors_en, wdt_expired, last_err, 3'b000};
  assign snap_src = (byte_idx == '0) ? enc_count : snap_q;
  assign duty     = wdt_expired ? '0 : duty_q;

  always_comb begin
    for (int i = 0; i < BUF_LEN; i++) begin
      buf_n[i] = req_buf[i];
      if (take && byte_idx == IDX_W'(i)) buf_n[i] = rx_byte;
    end
  end

  always_comb begin
    duty_new = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      duty_new[k*DUTY_WIDTH +: DUTY_WIDTH] = DUTY_WIDTH'({buf_n[2*k+2], buf_n[2*k+1]});
  end

  always_comb begin
    case (kind_n)
      K_UPD:   len_ok = (cnt_n == (IDX_W+1)'(BUF_LEN));
      K_RDD:   len_ok = (cnt_n == (IDX_W+1)'(1));
      K_SEN:   len_ok = (cnt_n == (IDX_W+1)'(2));
      default: len_ok = 1'b0;
    endcase
  end

  assign accept  = stop_evt & ~ovf_n & len_ok;
  assign upd_acc = accept & (kind_n == K_UPD);

  // Response for the byte following the one just received: channel = idx/2, MSB first.
  always_comb begin
    enc_sel  = '0;
    duty_sel = '0;
    tx_next  = 8'h00;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if ((byte_idx >> 1) == IDX_W'(k)) begin
        enc_sel  = snap_src[k*ENC_WIDTH +: ENC_WIDTH];
        duty_sel = duty[k*DUTY_WIDTH +: DUTY_WIDTH];
      end
    end
    if (byte_idx < IDX_W'(BUF_LEN - 1)) begin
      case (kind_n)
        K_UPD:   tx_next = pick_byte(16'(enc_sel), ~byte_idx[0]);
        K_RDD:   tx_next = pick_byte(16'(duty_sel), ~byte_idx[0]);
        K_BAD:   tx_next = 8'hAA;
        default: tx_next = 8'h00;
      endcase
    end
  end

  // Transfer tracking, register commits and watchdog.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      ncs_d       <= 1'b0;
      active      <= 1'b0;
      byte_idx    <= '0;
      overflow    <= 1'b0;
      kind_q      <= K_BAD;
      last_err    <= 1'b0;
      tx_byte     <= 8'hA8;
      duty_q      <= '0;
      motors_en   <= 1'b0;
      wdt_expired <= 1'b1;
      wdt_cnt     <= '0;
      commit      <= 1'b0;
      xfer_err    <= 1'b0;
    end else begin
      ncs_d    <= ncs_s;
      commit   <= 1'b0;
      xfer_err <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        byte_idx <= '0;
        overflow <= 1'b0;
        tx_byte  <= status;
      end else if (take) begin
        if (byte_idx != IDX_MAX) byte_idx <= byte_idx + 1'b1;
        overflow <= ovf_n;
        kind_q   <= kind_n;
        tx_byte  <= tx_next;
      end
      if (stop_evt) begin
        active <= 1'b0;
        if (accept) begin
          commit   <= 1'b1;
          last_err <= 1'b0;
          if (kind_n == K_SEN) motors_en <= buf_n[1][0];
        end else begin
          xfer_err <= 1'b1;
          last_err <= 1'b1;
        end
      end
      if (upd_acc) begin
        duty_q      <= duty_new;
        wdt_cnt     <= '0;
        wdt_expired <= 1'b0;
      end else if (wdt_expired) begin
        duty_q <= '0;
      end else if (wdt_cnt == WDT_LAST) begin
        wdt_cnt     <= wdt_cnt + 1'b1;
        wdt_expired <= 1'b1;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end

  // Request bytes and encoder snapshot carry no reset.
  always_ff @(posedge sysclk) begin
    for (int i = 0; i < BUF_LEN; i++)
      if (take && byte_idx == IDX_W'(i)) req_buf[i] <= rx_byte;
    if (take && byte_idx == '0) snap_q <= enc_count;
  end

endmodule

// File: tb/tb_spi_motor_cmd_ctrl.sv
// Randomised bench for spi_motor_cmd_ctrl against a transaction-level reference model.
module tb_spi_motor_cmd_ctrl;
  localparam int NCH = 4, DW = 10, EW = 16, TMO = 100, BUF_LEN = 9;

  logic              sysclk = 1'b0;
  logic              rst, ncs_s, byte_done;
  logic [7:0]        rx_byte;
  logic [NCH*EW-1:0] enc_count;
  logic [7:0]        tx_byte;
  logic [NCH*DW-1:0] duty;
  logic              motors_en, wdt_expired, commit, xfer_err;

  int ntests = 0, nfail = 0;
  int cyc = 0;

  bit         have_upd, m_en, m_err, last_acc;
  int         last_upd, last_stop;
  int         m_duty [NCH];
  int         m_snap [NCH];
  logic [7:0] pkt    [16];
  logic [7:0] cap_tx [17];

  spi_motor_cmd_ctrl #(.NUM_CHANNELS(NCH), .DUTY_WIDTH(DW), .ENC_WIDTH(EW),
                       .WDT_WIDTH(24), .WDT_TIMEOUT(TMO)) dut (
    .sysclk(sysclk), .rst(rst), .ncs_s(ncs_s), .byte_done(byte_done),
    .rx_byte(rx_byte), .enc_count(enc_count), .tx_byte(tx_byte), .duty(duty),
    .motors_en(motors_en), .wdt_expired(wdt_expired), .commit(commit), .xfer_err(xfer_err));

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish (got running, required done)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // State as visible after clock edge c.
  function automatic bit exp_expired(int c);
    return !have_upd || (c - last_upd >= TMO);
  endfunction

  function automatic int exp_duty(int c, int k);
    return exp_expired(c) ? 0 : m_duty[k];
  endfunction

  function automatic logic [NCH*DW-1:0] exp_duty_bus(int c);
    logic [NCH*DW-1:0] b = '0;
    for (int k = 0; k < NCH; k++) b[k*DW +: DW] = DW'(exp_duty(c, k));
    return b;
  endfunction

  function automatic logic [7:0] exp_resp(int j, logic [7:0] cmd, int c);
    int v, ch;
    if (j >= BUF_LEN) return 8'h00;
    ch = (j - 1) / 2;
    if (cmd[6:0] == 7'd0)  v = m_snap[ch];
    else if (cmd == 8'h81) v = exp_duty(c, ch);
    else if (cmd == 8'h02) return 8'h00;
    else                   return 8'hAA;
    if (j % 2 == 1) return 8'(v >> 8);
    return 8'(v & 255);
  endfunction

  task automatic run_xfer(input int n, input int stop_at, input bit merge, input bit scramble);
    int cs = -1;
    bit acc;
    @(negedge sysclk); ncs_s = 1'b0;
    @(negedge sysclk);
    chk("status", tx_byte, {2'b10, m_en, exp_expired(cyc - 1), m_err, 3'b000});
    for (int i = 0; i < n; i++) begin
      rx_byte = pkt[i];
      byte_done = 1'b1;
      if (i == 0) for (int k = 0; k < NCH; k++) m_snap[k] = int'(enc_count[k*EW +: EW]);
      if (merge && i == n - 1) ncs_s = 1'b1;
      @(negedge sysclk);
      byte_done = 1'b0;
      cap_tx[i+1] = tx_byte;
      chk("resp", tx_byte, exp_resp(i + 1, pkt[0], cyc - 1));
      if (merge && i == n - 1) cs = cyc;
      if (scramble) enc_count = {$urandom, $urandom};
      if (cs < 0) begin
        @(negedge sysclk);
        @(negedge sysclk);
      end
    end
    if (cs < 0) begin
      while (cyc < stop_at - 1) @(negedge sysclk);
      ncs_s = 1'b1;
      @(negedge sysclk);
      cs = cyc;
    end
    acc = (n > 0) && ((pkt[0][6:0] == 7'd0 && n == BUF_LEN) ||
                      (pkt[0] == 8'h81 && n == 1) || (pkt[0] == 8'h02 && n == 2));
    if (acc) begin
      m_err = 1'b0;
      if (pkt[0][6:0] == 7'd0) begin
        for (int k = 0; k < NCH; k++)
          m_duty[k] = ((int'(pkt[2*k+2]) << 8) | int'(pkt[2*k+1])) & ((1 << DW) - 1);
        have_upd = 1'b1;
        last_upd = cs;
      end
      if (pkt[0] == 8'h02) m_en = pkt[1][0];
    end else begin
      m_err = 1'b1;
    end
    chk("commit", commit, acc);
    chk("xfer_err", xfer_err, !acc);
    chk("duty", duty, exp_duty_bus(cs));
    chk("motors_en", motors_en, m_en);
    chk("wdt_expired", wdt_expired, exp_expired(cs));
    last_stop = cs;
    last_acc  = acc;
    @(negedge sysclk);
    chk("pulse_len", {commit, xfer_err}, 2'b00);
  endtask

  task automatic load_update(input int d0, input int d1, input int d2, input int d3);
    int d [4];
    d = '{d0, d1, d2, d3};
    pkt[0] = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      pkt[2*k+1] = 8'(d[k]);
      pkt[2*k+2] = 8'(d[k] >> 8);
    end
  endtask

  task automatic model_reset();
    have_upd = 1'b0; m_en = 1'b0; m_err = 1'b0;
    for (int k = 0; k < NCH; k++) m_duty[k] = 0;
  endtask

  initial begin
    logic [7:0] cmds [6];
    int e1, n, base;
    cmds = '{8'h00, 8'h80, 8'h81, 8'h02, 8'h7F, 8'h00};
    rst = 1'b1; ncs_s = 1'b1; byte_done = 1'b0; rx_byte = 8'h00; enc_count = '0;
    model_reset();
    repeat (3) @(negedge sysclk);
    chk("rst_tx", tx_byte, 8'hA8);
    chk("rst_duty", duty, '0);
    chk("rst_wdt", wdt_expired, 1'b1);
    chk("rst_en", motors_en, 1'b0);
    chk("rst_pulses", {commit, xfer_err}, 2'b00);
    rst = 1'b0;

    // Directed UPDATE with encoder data that changes mid-transfer.
    enc_count = {16'hBEEF, 16'h5A5A, 16'hC3C3, 16'h1234};
    load_update(16'h155, 16'h3FF, 16'h000, 16'h200);
    run_xfer(9, 0, 1'b0, 1'b1);
    chk("upd_duty_const", duty, 40'h80000FFD55);
    chk("enc_b1", cap_tx[1], 8'h12);
    chk("enc_b2", cap_tx[2], 8'h34);
    chk("enc_b7", cap_tx[7], 8'hBE);
    chk("enc_b8", cap_tx[8], 8'hEF);

    // Short, long and zero-byte transfers are rejected.
    load_update(16'h011, 16'h022, 16'h033, 16'h044);
    run_xfer(8, 0, 1'b0, 1'b0);
    run_xfer(10, 0, 1'b0, 1'b0);
    chk("dup_rejected", last_acc, 1'b0);
    run_xfer(0, 0, 1'b0, 1'b0);

    pkt[0] = 8'h02; pkt[1] = 8'h01;
    run_xfer(2, 0, 1'b0, 1'b0);
    chk("en_set", motors_en, 1'b1);
    pkt[0] = 8'h81;
    run_xfer(1, 0, 1'b0, 1'b0);
    run_xfer(9, 0, 1'b0, 1'b0);
    pkt[0] = 8'h7F;
    run_xfer(3, 0, 1'b0, 1'b0);
    chk("bad_cmd_aa", cap_tx[1], 8'hAA);

    // Random transfers.
    for (int t = 0; t < 40; t++) begin
      pkt[0] = cmds[$urandom_range(0, 5)];
      if (t % 6 == 5) pkt[0] = 8'($urandom);
      for (int i = 1; i < 16; i++) pkt[i] = 8'($urandom);
      base = (pkt[0][6:0] == 7'd0) ? 9 : (pkt[0] == 8'h81) ? 1 : (pkt[0] == 8'h02) ? 2 : 3;
      n = base;
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 1) ? base + 1 : base - 1;
      enc_count = {$urandom, $urandom};
      run_xfer(n, 0, (n > 0) && ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Watchdog expiry with no traffic after a valid UPDATE.
    load_update(16'h101, 16'h202, 16'h303, 16'h0FF);
    run_xfer(9, 0, 1'b0, 1'b0);
    e1 = last_stop;
    while (cyc < e1 + TMO - 1) @(negedge sysclk);
    chk("wdt_pre", wdt_expired, 1'b0);
    @(negedge sysclk);
    chk("wdt_exp", wdt_expired, 1'b1);
    chk("wdt_duty", duty, '0);

    // UPDATE committing in the expiry cycle keeps the watchdog alive.
    run_xfer(9, 0, 1'b0, 1'b0);
    e1 = last_stop;
    load_update(16'h3AA, 16'h155, 16'h001, 16'h2FE);
    run_xfer(9, e1 + TMO, 1'b0, 1'b0);
    chk("beat_time", last_stop, e1 + TMO);
    chk("beat_wdt", wdt_expired, 1'b0);

    // Reset in the middle of an UPDATE.
    @(negedge sysclk); ncs_s = 1'b0;
    @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      rx_byte = pkt[i]; byte_done = 1'b1;
      @(negedge sysclk); byte_done = 1'b0;
      @(negedge sysclk); @(negedge sysclk);
    end
    rst = 1'b1;
    @(negedge sysclk); @(negedge sysclk);
    model_reset();
    chk("mid_rst_tx", tx_byte, 8'hA8);
    chk("mid_rst_duty", duty, '0);
    chk("mid_rst_wdt", wdt_expired, 1'b1);
    rst = 1'b0;
    @(negedge sysclk); ncs_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      chk("mid_rst_pulses", {commit, xfer_err}, 2'b00);
    end
    load_update(16'h0AB, 16'h1CD, 16'h2EF, 16'h301);
    run_xfer(9, 0, 1'b0, 1'b0);
    chk("post_rst_commit", last_acc, 1'b1);

    repeat (2) @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
